// File: rtl/sfu_vec_collector_pkg.sv
// Shared types and helpers for the SFU vector collector.
// Consumers import sfu_pkg::*.
package sfu_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_POS_ZERO = 16'h0000;

    function automatic int len_w(input int cnt);
        return $clog2(cnt + 1);
    endfunction

endpackage

// File: rtl/sfu_vec_collector_if.sv
// Element stream in, parallel vector out, consumer release back.
// master = producer/consumer side, slave = collector.
interface sfu_vec_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_CNT   = 64,
    parameter int LEN_W      = sfu_pkg::len_w(DATA_CNT)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_start;
    logic [DATA_WIDTH-1:0] out_array [DATA_CNT];
    logic [LEN_W-1:0]      out_len;
    logic                  out_done;

    modport master (
        output in_valid, in_data, in_last, out_done,
        input  in_ready, out_valid, out_start, out_array, out_len
    );

    modport slave (
        input  in_valid, in_data, in_last, out_done,
        output in_ready, out_valid, out_start, out_array, out_len
    );
endinterface

// File: rtl/sfu_vec_collector_bank.sv
// One storage bank: write pointer, length register, padded read view.
// Early close on last_i only with SFU_ZERO_PAD_EN.
module sfu_vec_bank
    import sfu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_CNT   = 64,
    parameter int LEN_W      = len_w(DATA_CNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    output logic                  close_o,
    output logic [LEN_W-1:0]      len_o,
    output logic [DATA_WIDTH-1:0] arr_o [DATA_CNT]
);
    localparam int PTR_W = $clog2(DATA_CNT);

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [DATA_WIDTH-1:0] mem_q [DATA_CNT];
    logic                  end_hit;

    assign end_hit = (ptr_q == PTR_W'(DATA_CNT - 1));

`ifdef SFU_ZERO_PAD_EN
    assign close_o = wr_i && (end_hit || last_i);
`else
    logic unused_last;
    assign unused_last = last_i;
    assign close_o     = wr_i && end_hit;
`endif

    always_comb begin
        ptr_d = ptr_q;
        len_d = len_q;
        if (close_o) begin
            ptr_d = '0;
            len_d = LEN_W'(ptr_q) + LEN_W'(1);
        end else if (wr_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            len_q <= '0;
            for (int i = 0; i < DATA_CNT; i++)
                mem_q[i] <= DATA_WIDTH'(FP16_POS_ZERO);
        end else begin
            ptr_q <= ptr_d;
            len_q <= len_d;
            if (wr_i)
                mem_q[ptr_q] <= data_i;
        end
    end

    // Stale entries from an earlier, longer vector must read as +0.
    always_comb begin
        for (int i = 0; i < DATA_CNT; i++) begin
`ifdef SFU_ZERO_PAD_EN
            arr_o[i] = (LEN_W'(i) < len_q) ? mem_q[i]
                                           : DATA_WIDTH'(FP16_POS_ZERO);
`else
            arr_o[i] = mem_q[i];
`endif
        end
    end

    assign len_o = len_q;

endmodule

// File: rtl/sfu_vec_collector.sv
// Ping-pong FP16 vector collector feeding the SFU array accumulator.
// Optional early close with zero padding: define SFU_ZERO_PAD_EN.
module sfu_vec_collector
    import sfu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_CNT   = 64
) (
    input logic     clk,
    input logic     rst,
    sfu_vec_if.slave io
);
    localparam int LEN_W = len_w(DATA_CNT);

    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [1:0]            full_q, full_d;
    logic                  started_q, started_d;
    logic                  in_ready;
    logic                  out_valid;
    logic                  accept;
    logic                  release_v;
    logic [1:0]            close;
    logic [LEN_W-1:0]      len [2];
    logic [DATA_WIDTH-1:0] arr [2][DATA_CNT];

    assign in_ready  = !full_q[wr_sel_q];
    assign accept    = io.in_valid && in_ready;
    assign out_valid = full_q[rd_sel_q];
    assign release_v = io.out_done && out_valid;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sfu_vec_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DATA_CNT   (DATA_CNT),
            .LEN_W      (LEN_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_i    (accept && (wr_sel_q == 1'(b))),
            .data_i  (io.in_data),
            .last_i  (io.in_last),
            .close_o (close[b]),
            .len_o   (len[b]),
            .arr_o   (arr[b])
        );
    end

    // Close and release never target the same bank in one cycle.
    always_comb begin
        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        if (|close) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = !wr_sel_q;
        end
        if (release_v) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
        end
        started_d = release_v ? 1'b0 : out_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            full_q    <= '0;
            started_q <= 1'b0;
        end else begin
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            full_q    <= full_d;
            started_q <= started_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid;
    assign io.out_start = out_valid && !started_q;
    assign io.out_len   = out_valid ? len[rd_sel_q] : '0;

    always_comb begin
        for (int i = 0; i < DATA_CNT; i++)
            io.out_array[i] = arr[rd_sel_q][i];
    end

endmodule
